// File: rtl/ay_bus_master.sv
// rtl/ay_bus_master.sv - AY-slot bus initiator: byte commands to timed BDIR/BC1/BC2/A8/A9_n cycles
// Build option AYBUS_READ_EN: when defined, read ops run a full bus cycle and sample ay_d_in.
module ay_bus_master #(
    parameter int SETUP_CYC  = 3,
    parameter int STROBE_CYC = 28,
    parameter int HOLD_CYC   = 3,
    parameter int GAP_CYC    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       ay_bdir,
    output logic       ay_bc1,
    output logic       ay_bc2,
    output logic       ay_a8,
    output logic       ay_a9_n,
    output logic [7:0] ay_d_out,
    output logic       ay_d_oe,
    input  logic [7:0] ay_d_in
);

    localparam logic [1:0] OP_ADDR  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    localparam logic [5:0] SETUP_LD  = 6'(SETUP_CYC - 1);
    localparam logic [5:0] STROBE_LD = 6'(STROBE_CYC - 1);
    localparam logic [5:0] HOLD_LD   = 6'(HOLD_CYC - 1);
    localparam logic [5:0] GAP_LD    = 6'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t     state, state_nxt;
    logic [5:0] cnt, cnt_nxt;
    logic [1:0] op_q, op_nxt;
    logic [7:0] byte_q, byte_nxt;

    logic       cmd_ready_nxt;
    logic       rsp_valid_nxt;
    logic [7:0] rsp_data_nxt;
    logic       bdir_nxt;
    logic       bc1_nxt;
    logic       a8_nxt;
    logic       a9_n_nxt;
    logic [7:0] d_out_nxt;
    logic       d_oe_nxt;
    logic       sel_nxt;
    logic       strobe_nxt;

    // BC2 is strapped high; only BDIR/BC1 encode the bus phase.
    assign ay_bc2 = 1'b1;

`ifndef AYBUS_READ_EN
    logic unused_d_in;
    assign unused_d_in = ^ay_d_in;
`endif

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        op_nxt        = op_q;
        byte_nxt      = byte_q;
        rsp_valid_nxt = 1'b0;
        rsp_data_nxt  = rsp_data;

        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_ADDR, OP_WRITE: begin
                            op_nxt    = cmd_op;
                            byte_nxt  = cmd_data;
                            cnt_nxt   = SETUP_LD;
                            state_nxt = ST_SETUP;
                        end
                        OP_READ: begin
`ifdef AYBUS_READ_EN
                            op_nxt    = cmd_op;
                            byte_nxt  = cmd_data;
                            cnt_nxt   = SETUP_LD;
                            state_nxt = ST_SETUP;
`else
                            rsp_valid_nxt = 1'b1;
                            rsp_data_nxt  = 8'hFF;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            ST_SETUP: begin
                if (cnt == 6'd0) begin
                    cnt_nxt   = STROBE_LD;
                    state_nxt = ST_STROBE;
                end else begin
                    cnt_nxt = cnt - 6'd1;
                end
            end
            ST_STROBE: begin
                if (cnt == 6'd0) begin
                    cnt_nxt   = HOLD_LD;
                    state_nxt = ST_HOLD;
`ifdef AYBUS_READ_EN
                    // Sample on the last strobe cycle so the byte is valid for the first HOLD cycle.
                    if (op_q == OP_READ) begin
                        rsp_valid_nxt = 1'b1;
                        rsp_data_nxt  = ay_d_in;
                    end
`endif
                end else begin
                    cnt_nxt = cnt - 6'd1;
                end
            end
            ST_HOLD: begin
                if (cnt == 6'd0) begin
                    cnt_nxt   = GAP_LD;
                    state_nxt = ST_GAP;
                end else begin
                    cnt_nxt = cnt - 6'd1;
                end
            end
            ST_GAP: begin
                if (cnt == 6'd0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 6'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Bus outputs are decoded from the next state so they land in registers.
        sel_nxt       = (state_nxt == ST_SETUP) || (state_nxt == ST_STROBE) || (state_nxt == ST_HOLD);
        strobe_nxt    = (state_nxt == ST_STROBE);
        cmd_ready_nxt = (state_nxt == ST_IDLE);
        a8_nxt        = sel_nxt;
        a9_n_nxt      = !sel_nxt;
        d_oe_nxt      = sel_nxt && (op_nxt != OP_READ);
        d_out_nxt     = d_oe_nxt ? byte_nxt : 8'h00;
        bdir_nxt      = strobe_nxt && (op_nxt != OP_READ);
        bc1_nxt       = strobe_nxt && (op_nxt != OP_WRITE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 6'd0;
            op_q      <= OP_ADDR;
            byte_q    <= 8'h00;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'hFF;
            ay_bdir   <= 1'b0;
            ay_bc1    <= 1'b0;
            ay_a8     <= 1'b0;
            ay_a9_n   <= 1'b1;
            ay_d_out  <= 8'h00;
            ay_d_oe   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            op_q      <= op_nxt;
            byte_q    <= byte_nxt;
            cmd_ready <= cmd_ready_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
            ay_bdir   <= bdir_nxt;
            ay_bc1    <= bc1_nxt;
            ay_a8     <= a8_nxt;
            ay_a9_n   <= a9_n_nxt;
            ay_d_out  <= d_out_nxt;
            ay_d_oe   <= d_oe_nxt;
        end
    end

endmodule

// File: tb/tb_ay_bus_master.sv
// tb/tb_ay_bus_master.sv - directed bench for ay_bus_master with response scoreboard
module tb_ay_bus_master;

    localparam int S     = 3;
    localparam int T     = 28;
    localparam int H     = 3;
    localparam int G     = 8;
    localparam int TOTAL = S + T + H + G + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       ay_bdir;
    logic       ay_bc1;
    logic       ay_bc2;
    logic       ay_a8;
    logic       ay_a9_n;
    logic [7:0] ay_d_out;
    logic       ay_d_oe;
    logic [7:0] ay_d_in;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] data;
        int         at;
    } rsp_t;

    rsp_t sb[$];

    ay_bus_master #(
        .SETUP_CYC (S),
        .STROBE_CYC(T),
        .HOLD_CYC  (H),
        .GAP_CYC   (G)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .ay_bdir  (ay_bdir),
        .ay_bc1   (ay_bc1),
        .ay_bc2   (ay_bc2),
        .ay_a8    (ay_a8),
        .ay_a9_n  (ay_a9_n),
        .ay_d_out (ay_d_out),
        .ay_d_oe  (ay_d_oe),
        .ay_d_in  (ay_d_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // {cmd_ready, bdir, bc1, bc2, a8, a9_n, oe} at offset k after acceptance.
    function automatic logic [6:0] exp_ctl(input logic [1:0] op, input int k);
        logic sel;
        logic strb;
        sel  = (k >= 1) && (k <= S + T + H);
        strb = (k > S) && (k <= S + T);
        return {k >= TOTAL, strb && (op != 2'b10), strb && (op != 2'b01), 1'b1,
                sel, !sel, sel && (op != 2'b10)};
    endfunction

    function automatic logic [6:0] obs_ctl();
        return {cmd_ready, ay_bdir, ay_bc1, ay_bc2, ay_a8, ay_a9_n, ay_d_oe};
    endfunction

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            check("rsp_sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                rsp_t e;
                e = sb.pop_front();
                check("rsp_data", {24'd0, rsp_data}, {24'd0, e.data});
                check("rsp_cycle", cyc, e.at);
            end
        end
    end

    task automatic send_cmd(input logic [1:0] op, input logic [7:0] data, output int acc);
        int wait_n;
        wait_n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        while (cmd_ready !== 1'b1 && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
        end
        check("accept_wait", {31'd0, wait_n < 100}, 32'd1);
        @(posedge clk);
        #1;
        acc = cyc;
    endtask

    task automatic run_bus(input logic [1:0] op, input logic [7:0] data, input bit hold_valid,
                           input string nm);
        int   acc;
        rsp_t e;
        if (op == 2'b10) ay_d_in = data;
        send_cmd(op, data, acc);
        if (!hold_valid) begin
            cmd_valid = 1'b0;
            cmd_data  = ~data;
        end
        if (op == 2'b10) begin
            e.data = data;
            e.at   = acc + S + T;
            sb.push_back(e);
        end
        for (int k = 1; k <= TOTAL; k++) begin
            check($sformatf("%s ctl k=%0d", nm, k), {25'd0, obs_ctl()}, {25'd0, exp_ctl(op, k)});
            if (k <= S + T + H && op != 2'b10)
                check($sformatf("%s dout k=%0d", nm, k), {24'd0, ay_d_out}, {24'd0, data});
            if (op == 2'b10 && k == S + T + 1) ay_d_in = 8'hFF;
            if (op == 2'b10 && k == TOTAL)
                check($sformatf("%s rsp_hold", nm), {24'd0, rsp_data}, {24'd0, data});
            if (k < TOTAL) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic check_idle(input string nm, input int n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s idle i=%0d", nm, i), {25'd0, obs_ctl()}, {25'd0, 7'b1001010});
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 8'h00;
        ay_d_in   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset ctl", {25'd0, obs_ctl()}, {25'd0, 7'b1001010});
        check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset rsp_data", {24'd0, rsp_data}, 32'h0000_00FF);
        check("reset dout", {24'd0, ay_d_out}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_idle("post_reset", 2);

        run_bus(2'b00, 8'h07, 1'b0, "addr");

        run_bus(2'b01, 8'hA5, 1'b1, "wr1");
        run_bus(2'b01, 8'hA5, 1'b0, "wr2");

`ifdef AYBUS_READ_EN
        run_bus(2'b10, 8'h3C, 1'b0, "rd");
`else
        begin
            rsp_t e;
            ay_d_in = 8'h3C;
            send_cmd(2'b10, 8'h00, acc);
            cmd_valid = 1'b0;
            e.data = 8'hFF;
            e.at   = acc;
            sb.push_back(e);
            check_idle("rd_off", 3);
            check("rd_off rsp_data", {24'd0, rsp_data}, 32'h0000_00FF);
        end
`endif

        send_cmd(2'b11, 8'h33, acc);
        cmd_valid = 1'b0;
        check_idle("rsvd", 4);

        send_cmd(2'b01, 8'h96, acc);
        cmd_valid = 1'b0;
        repeat (S + 9) begin
            @(posedge clk);
            #1;
        end
        check("mid_strobe bdir", {31'd0, ay_bdir}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid ctl", {25'd0, obs_ctl()}, {25'd0, 7'b1001010});
        check("rst_mid dout", {24'd0, ay_d_out}, 32'd0);
        check("rst_mid rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_mid rsp_data", {24'd0, rsp_data}, 32'h0000_00FF);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_idle("after_rst", 3);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
